pc_seq: RTL
===========

# pc_seq

Parametrised program sequencer that replaces the fixed program counter, branch lookup table and `done` logic of the single-cycle core top level. It owns the `req`/`done` run handshake and generates `prog_ctr` for the instruction ROM. It supports absolute and PC-relative branches through a writable target table, a stall input, a cycle counter and an optional hardware call/return stack. Control and instruction-decode logic feed it one-bit event strobes each cycle.

## Interface

Parameters:
- `D`, default 8: program counter width.
- `LW`, default 5: branch-table index width; the table has 2^LW entries of D bits each.
- `SD`, default 4: call-stack depth in entries. Used only when `CALL_STACK_EN` is defined.

Ports:
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req`  input  1  run request, level.
- `halt`  input  1  decoded halt instruction.
- `stall`  input  1  hold PC this cycle.
- `branch`  input  1  taken branch.
- `br_rel`  input  1  1 = relative (PC + signed table entry); 0 = absolute.
- `br_idx`  input  LW  branch-table index.
- `call`  input  1  subroutine call (absolute target `lut[br_idx]`).
- `ret`  input  1  subroutine return.
- `lut_we`  input  1  branch-table write enable.
- `lut_waddr`  input  LW  branch-table write index.
- `lut_wdata`  input  D  branch-table write data.
- `prog_ctr`  output  D  current instruction address.
- `running`  output  1  state is RUN.
- `done`  output  1  state is DONE.
- `err`  output  1  sticky stack fault.
- `cyc_cnt`  output  16  RUN cycles elapsed, saturating.

## Operation

- **States:** IDLE, RUN, DONE. Reset enters IDLE.
- **Reset values:** `prog_ctr`=0, `running`=0, `done`=0, `err`=0, `cyc_cnt`=0, all table entries 0, stack empty.
- **IDLE:**
  - `prog_ctr` is held at 0.
  - `req`=1 → RUN. `prog_ctr` stays 0, `cyc_cnt` is cleared to 0 and `err` is cleared.
- **RUN:** each cycle, the first matching rule applies:
  1. `stall` → PC held; all events are ignored.
  2. `halt` → DONE; PC held.
  3. `ret` → PC = popped address.
  4. `call` → push PC+1; PC = `lut[br_idx]`.
  5. `branch` → PC = `br_rel` ? PC + `lut[br_idx]` (two's complement, modulo 2^D) : `lut[br_idx]`.
  6. Otherwise, if PC = 2^D−1 → DONE with PC held (end of program).
  7. Otherwise PC = PC+1.
- **Cycle counter:** `cyc_cnt` increments on every RUN cycle, including stalls, and saturates at 0xFFFF.
- **DONE:**
  - PC is held.
  - Exits to IDLE once `req`=0.
  - A `req` held high never re-launches a run; it must drop first.
- **`req` during RUN:** `req` falling during RUN does not abort the run.
- **Branch table:**
  - Writes are accepted in IDLE and DONE only; `lut_we` in RUN is ignored.
  - Reads are combinational on `br_idx`.
  - A write and a read of the same entry in the same cycle return the old value.
- **Relative wrap:** relative branches wrap silently. An increment past 2^D−1 does not occur, because rule 6 ends the run first.

## Timing

- All outputs are registered.
- An event sampled at edge *n* is visible on `prog_ctr` after edge *n*.
- `req` sampled in IDLE → `running`=1 one cycle later.
- `halt` sampled → `running`=0 and `done`=1 one cycle later.
- `req`=0 sampled in DONE → `done`=0 the next cycle.
- Asserting `reset` low mid-run immediately forces all reset values, including clearing the table and the stack.
- Event inputs are ignored outside RUN.

## Configuration

- **`CALL_STACK_EN` defined:**
  - An SD-entry LIFO of D-bit return addresses is built in.
  - `call` with the stack full, or `ret` with the stack empty, sets `err`=1, leaves PC unchanged and enters DONE next cycle.
  - The stack is emptied on entry to RUN.
- **`CALL_STACK_EN` undefined:**
  - No stack is built.
  - `call` and `ret` are ignored; rule 5 is evaluated directly.
  - `err` is tied to 0.

## Test plan

- Reset, then `req`=1 with no events → `prog_ctr` 0,1,2,…; with D=8, 255 is reached and held, `done`=1, and `cyc_cnt`=256.
- IDLE write `lut[3]`=0x40, run, `branch`=1, `br_rel`=0, `br_idx`=3 at PC=5 → next PC=0x40. Repeat with `lut[3]`=0xFE and `br_rel`=1 → next PC=3.
- `stall`=1 for 3 cycles at PC=7 together with `branch`=1 → PC stays 7 for 3 cycles, `cyc_cnt` still advances, and the branch is not taken.
- `halt` at PC=9 while `req` is held high → `done`=1 and PC=9 held. `req`=0 → IDLE and PC=0; `req` re-raised → new run and `cyc_cnt` cleared.
- `CALL_STACK_EN`, SD=4:
  - Call at PC=2 to `lut[0]`=0x20, then `ret` → PC=3.
  - Five nested calls → the fifth sets `err`=1 and `done`=1.
  - `ret` on an empty stack → `err`=1.
- Drive `reset` low mid-run at PC=0x33 between clock edges → `prog_ctr`=0, `running`=0 and `lut[3]`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_seq_if.sv
// Run handshake, event strobes, branch-table write port and status outputs
// of the program sequencer, bundled for connection to the core top level.
interface pc_seq_if #(
  parameter int D  = 8,
  parameter int LW = 5
);
  logic          req;
  logic          halt;
  logic          stall;
  logic          branch;
  logic          br_rel;
  logic [LW-1:0] br_idx;
  logic          call;
  logic          ret;
  logic          lut_we;
  logic [LW-1:0] lut_waddr;
  logic [D-1:0]  lut_wdata;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic          err;
  logic [15:0]   cyc_cnt;

  // Control/decode side drives events and reads status.
  modport master (
    output req, halt, stall, branch, br_rel, br_idx, call, ret,
           lut_we, lut_waddr, lut_wdata,
    input  prog_ctr, running, done, err, cyc_cnt
  );

  // Sequencer side.
  modport slave (
    input  req, halt, stall, branch, br_rel, br_idx, call, ret,
           lut_we, lut_waddr, lut_wdata,
    output prog_ctr, running, done, err, cyc_cnt
  );
endinterface

// File: rtl/pc_seq.sv
// Program sequencer: IDLE/RUN/DONE run handshake, program counter with
// absolute/relative branches through a writable target table, stall,
// saturating RUN cycle counter.
// Optional hardware call/return stack: define CALL_STACK_EN.
module pc_seq #(
  parameter int D  = 8,
  parameter int LW = 5,
  parameter int SD = 4
) (
  input logic     clk,
  input logic     reset,
  pc_seq_if.slave bus
);
  localparam int NE = 1 << LW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       state_reg;
  logic [D-1:0] pc_reg;
  logic         running_reg;
  logic         done_reg;
  logic [15:0]  cyc_reg;
  logic [D-1:0] lut_reg [NE];

  logic [D-1:0] lut_rd;
  logic [D-1:0] pc_inc;
  logic [D-1:0] br_target;

  // A depth below one is meaningless; this keeps SD part of every build.
  if (SD < 1) begin : g_sd_invalid
  end

  assign lut_rd    = lut_reg[bus.br_idx];
  assign pc_inc    = pc_reg + D'(1);
  // Relative targets wrap modulo 2^D by plain D-bit addition.
  assign br_target = bus.br_rel ? (pc_reg + lut_rd) : lut_rd;

  assign bus.prog_ctr = pc_reg;
  assign bus.running  = running_reg;
  assign bus.done     = done_reg;
  assign bus.cyc_cnt  = cyc_reg;

  // Branch table: cleared by reset, writable only while not running, so a
  // same-cycle read always sees the pre-write contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NE; i++) lut_reg[i] <= '0;
    end else if (bus.lut_we && state_reg != S_RUN) begin
      lut_reg[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

`ifdef CALL_STACK_EN
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;
  localparam int PW = $clog2(SD + 1);

  logic [D-1:0]  stack_reg [SD];
  logic [PW-1:0] sp_reg;
  logic          err_reg;
  logic          stk_empty;
  logic          stk_full;
  logic          push_en;
  logic [D-1:0]  stk_top;

  assign stk_empty = (sp_reg == '0);
  assign stk_full  = (sp_reg == PW'(SD));
  assign stk_top   = stack_reg[AW'(sp_reg - PW'(1))];
  // A call only pushes when no higher-priority event wins and room exists.
  assign push_en   = (state_reg == S_RUN) && !bus.stall && !bus.halt &&
                     !bus.ret && bus.call && !stk_full;
  assign bus.err   = err_reg;

  // Return-address storage; emptiness is tracked by sp_reg alone.
  always_ff @(posedge clk) begin
    if (push_en) stack_reg[AW'(sp_reg)] <= pc_inc;
  end
`else
  assign bus.err = 1'b0;
`endif

  // Run-control FSM with registered PC, status and cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      pc_reg      <= '0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      cyc_reg     <= '0;
`ifdef CALL_STACK_EN
      sp_reg      <= '0;
      err_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          pc_reg <= '0;
          if (bus.req) begin
            state_reg   <= S_RUN;
            running_reg <= 1'b1;
            cyc_reg     <= '0;
`ifdef CALL_STACK_EN
            sp_reg      <= '0;
            err_reg     <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (cyc_reg != 16'hFFFF) cyc_reg <= cyc_reg + 16'd1;
          if (!bus.stall) begin
            if (bus.halt) begin
              state_reg   <= S_DONE;
              running_reg <= 1'b0;
              done_reg    <= 1'b1;
            end
`ifdef CALL_STACK_EN
            else if (bus.ret) begin
              if (stk_empty) begin
                err_reg     <= 1'b1;
                state_reg   <= S_DONE;
                running_reg <= 1'b0;
                done_reg    <= 1'b1;
              end else begin
                pc_reg <= stk_top;
                sp_reg <= sp_reg - PW'(1);
              end
            end else if (bus.call) begin
              if (stk_full) begin
                err_reg     <= 1'b1;
                state_reg   <= S_DONE;
                running_reg <= 1'b0;
                done_reg    <= 1'b1;
              end else begin
                pc_reg <= lut_rd;
                sp_reg <= sp_reg + PW'(1);
              end
            end
`endif
            else if (bus.branch) begin
              pc_reg <= br_target;
            end else if (pc_reg == '1) begin
              // Last address executed: end of program, PC held.
              state_reg   <= S_DONE;
              running_reg <= 1'b0;
              done_reg    <= 1'b1;
            end else begin
              pc_reg <= pc_inc;
            end
          end
        end
        S_DONE: begin
          // A held req never relaunches; it must drop back through IDLE.
          if (!bus.req) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b0;
            pc_reg    <= '0;
          end
        end
        default: begin
          state_reg   <= S_IDLE;
          pc_reg      <= '0;
          running_reg <= 1'b0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end
endmodule
